// File: rtl/arm_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_fetch_pkg
//  Purpose  : Shared types and constants for the instruction-fetch path
//  Revision : 1.0 - initial release
// ============================================================================
package arm_fetch_pkg;

  // Bytes per instruction word; the low log2 bits of an address must be zero
  localparam int WORD_BYTES = 4;

  // Word returned for misaligned or out-of-range fetches
  localparam logic [31:0] INST_ERR_WORD = 32'h0000_0000;

  // Responder control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder_if
//  Purpose  : Fetch request / response channel between fetch stage (master)
//             and instruction memory responder (slave)
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_responder_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_inst;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;

  // Fetch stage side
  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );

  // Memory responder side
  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
//  Module   : imem_array
//  Purpose  : DEPTH x 32 instruction storage, combinational read port and
//             synchronous write port; contents survive reset
//  Revision : 1.0 - initial release
// ============================================================================
module imem_array #(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we_i,
  input  wire logic [IDX_W-1:0] waddr_i,
  input  wire logic [31:0]      wdata_i,
  input  wire logic [IDX_W-1:0] raddr_i,
  output logic      [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Word write; a read of the same word in this cycle still sees old data
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder
//  Purpose  : Multi-cycle instruction memory responder. Accepts one fetch
//             at a time, waits WAIT_STATES cycles, then presents the word
//             (or an error) on a valid/ready response channel. Flush drops
//             any in-flight work; a load port fills the array.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_responder
  import arm_fetch_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,       // asynchronous, active low
  imem_responder_if.slave        bus,
  input  wire logic              ld_en,
  input  wire logic [ADDR_W-1:0] ld_addr,
  input  wire logic [31:0]       ld_data
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         OFF_W     = $clog2(WORD_BYTES);
  localparam logic [3:0] WS_INIT   = 4'(WAIT_STATES);
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);

  imem_state_t       state_q;
  logic [3:0]        cnt_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_inst_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic              rsp_err_q;

  logic              w_req_ready;
  logic              w_req_fire;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_err;
  logic [31:0]       w_rd_data;
  logic [31:0]       w_inst_d;
  logic              w_unused_ld;

  // Flush blocks acceptance; in RESP a new request rides on the response handshake
  assign w_req_ready = !bus.flush &&
                       ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));
  assign w_req_fire  = bus.req_valid && w_req_ready;

  // With no wait states the array is read in the accepting cycle, so the
  // incoming address drives the read; otherwise the captured one does
  assign w_rd_addr = ZERO_WAIT ? bus.req_addr : rsp_addr_q;
  assign w_rd_err  = (w_rd_addr[OFF_W-1:0] != '0) ||
                     ((w_rd_addr >> (IDX_W + OFF_W)) != '0);
  assign w_inst_d  = w_rd_err ? INST_ERR_WORD : w_rd_data;

  // Only the word-index bits of the load address select storage
  assign w_unused_ld = ^ld_addr;

  imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (ld_en),
    .waddr_i (ld_addr[IDX_W+OFF_W-1:OFF_W]),
    .wdata_i (ld_data),
    .raddr_i (w_rd_addr[IDX_W+OFF_W-1:OFF_W]),
    .rdata_o (w_rd_data)
  );

  // Control FSM with wait counter and registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= 32'd0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (w_req_fire) begin
            rsp_addr_q <= bus.req_addr;
            if (ZERO_WAIT) begin
              state_q     <= ST_RESP;
              cnt_q       <= 4'd0;
              rsp_valid_q <= 1'b1;
              rsp_inst_q  <= w_inst_d;
              rsp_err_q   <= w_rd_err;
            end else begin
              state_q     <= ST_WAIT;
              cnt_q       <= WS_INIT;
              rsp_valid_q <= 1'b0;
            end
          end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= ST_RESP;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= w_inst_d;
            rsp_err_q   <= w_rd_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_inst  = rsp_inst_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
